fetch_stage: RTL and testbench

- Program-counter and instruction-fetch stage that drives the address of the asynchronous instruction ROM and samples the returned word.
- Owns the PC register, boot sequencing, branch/jump redirect, halt and back-pressure toward decode.
- Presents a registered IF/ID output (instruction, PC, PC+4, fault flag) with a valid/ready handshake.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, boot/halt sequencing and redirect handling,
// and presents a registered IF/ID entry to decode through a valid/ready handshake.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'hBFC00000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     halt_req,
    input  logic                     id_ready,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [ADDRESS_WIDTH-1:0] if_pc_plus4,
    output logic                     if_fault,
    output logic                     halted
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = {{(ADDRESS_WIDTH-3){1'b0}}, 3'b100};

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [1:0]               r_state;
    logic                     r_fault_pending;
    logic                     r_halted;
    logic                     r_if_valid;
    logic [DATA_WIDTH-1:0]    r_if_instr;
    logic [ADDRESS_WIDTH-1:0] r_if_pc;
    logic [ADDRESS_WIDTH-1:0] r_if_pc_plus4;
    logic                     r_if_fault;

    logic                     w_fire;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [ADDRESS_WIDTH-1:0] w_pc_next;
    logic [1:0]               w_state_next;
    logic                     w_fault_pending_next;
    logic                     w_if_valid_next;
    logic [DATA_WIDTH-1:0]    w_if_instr_next;
    logic [ADDRESS_WIDTH-1:0] w_if_pc_next;
    logic [ADDRESS_WIDTH-1:0] w_if_pc_plus4_next;
    logic                     w_if_fault_next;

    assign w_pc_plus4 = r_pc + PC_STEP;
    assign w_fire     = (r_state == ST_RUN) && !halt_req && !redirect_valid
                        && (!r_if_valid || id_ready);

    // Next-state: redirect overrides everything, then per-state fetch/drain/halt
    always_comb begin
        w_pc_next            = r_pc;
        w_state_next         = r_state;
        w_fault_pending_next = r_fault_pending;
        w_if_valid_next      = r_if_valid;
        w_if_instr_next      = r_if_instr;
        w_if_pc_next         = r_if_pc;
        w_if_pc_plus4_next   = r_if_pc_plus4;
        w_if_fault_next      = r_if_fault;
        if (redirect_valid) begin
            w_if_valid_next      = 1'b0;
            w_pc_next            = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
            w_fault_pending_next = (redirect_target[1:0] != 2'b00);
            w_state_next         = ST_RUN;
        end else if (w_fire) begin
            w_if_instr_next      = imem_instr;
            w_if_pc_next         = r_pc;
            w_if_pc_plus4_next   = w_pc_plus4;
            w_if_fault_next      = r_fault_pending;
            w_if_valid_next      = 1'b1;
            w_pc_next            = w_pc_plus4;
            w_fault_pending_next = 1'b0;
        end else begin
            if (r_if_valid && id_ready) begin
                w_if_valid_next = 1'b0;
            end else begin
                w_if_valid_next = r_if_valid;
            end
            case (r_state)
                ST_BOOT:   w_state_next = ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        w_state_next = ST_HALTED;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_HALTED: w_state_next = ST_HALTED;
                // An illegal encoding restarts boot sequencing with the entry flushed
                default: begin
                    w_state_next    = ST_BOOT;
                    w_if_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State and IF/ID register update with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_VECTOR;
            r_state         <= ST_BOOT;
            r_fault_pending <= 1'b0;
            r_halted        <= 1'b0;
            r_if_valid      <= 1'b0;
            r_if_instr      <= {DATA_WIDTH{1'b0}};
            r_if_pc         <= {ADDRESS_WIDTH{1'b0}};
            r_if_pc_plus4   <= {ADDRESS_WIDTH{1'b0}};
            r_if_fault      <= 1'b0;
        end else begin
            r_pc            <= w_pc_next;
            r_state         <= w_state_next;
            r_fault_pending <= w_fault_pending_next;
            r_halted        <= (w_state_next == ST_HALTED);
            r_if_valid      <= w_if_valid_next;
            r_if_instr      <= w_if_instr_next;
            r_if_pc         <= w_if_pc_next;
            r_if_pc_plus4   <= w_if_pc_plus4_next;
            r_if_fault      <= w_if_fault_next;
        end
    end

    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_fault    = r_if_fault;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID entries are queued as stimulus is
// driven and compared when the stage presents them.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_fault;
    logic        halted;

    entry_t sb[$];
    entry_t e;
    int     n_checks;
    int     n_errors;

    fetch_stage #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .RESET_VECTOR (32'hBFC00000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_fault       (if_fault),
        .halted         (halted)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h00500093;
        return a ^ 32'h13579BDF;
    endfunction

    assign imem_instr = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic f);
        sb.push_back('{pc, rom(pc), f});
    endtask

    task automatic test_reset();
        rst = 1'b1; id_ready = 1'b1; halt_req = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        tick(); tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr, if_pc_plus4, if_fault, halted} !== {1'b0, 96'h0, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL reset_outputs: got v=%b pc=%h instr=%h p4=%h f=%b h=%b, expected all zero",
                                 if_valid, if_pc, if_instr, if_pc_plus4, if_fault, halted);
        end
        n_checks++;
        if (imem_addr !== 32'hBFC00000) begin
            n_errors++; $display("FAIL reset_addr: got %h expected bfc00000", imem_addr);
        end
    endtask

    task automatic test_boot();
        rst = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_errors++; $display("FAIL boot_edge1: if_valid got %b expected 0", if_valid);
        end
        for (int i = 0; i < 2; i++) begin
            push(32'hBFC00000 + 32'(4 * i), 1'b0);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({if_valid, if_pc, if_instr, if_pc_plus4, if_fault} !== {1'b1, e.pc, e.instr, e.pc + 32'd4, e.fault}) begin
                n_errors++; $display("FAIL boot_entry%0d: got v=%b pc=%h instr=%h p4=%h f=%b expected pc=%h instr=%h",
                                     i, if_valid, if_pc, if_instr, if_pc_plus4, if_fault, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_backpressure();
        push(32'hBFC00008, 1'b0);
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, e.pc, e.instr}) begin
            n_errors++; $display("FAIL bp_pre: got v=%b pc=%h instr=%h expected pc=%h", if_valid, if_pc, if_instr, e.pc);
        end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if_valid, if_pc, if_instr, if_pc_plus4, imem_addr} !== {1'b1, 32'hBFC00008, rom(32'hBFC00008), 32'hBFC0000C, 32'hBFC0000C}) begin
                n_errors++; $display("FAIL bp_hold%0d: got v=%b pc=%h addr=%h expected pc=bfc00008 addr=bfc0000c",
                                     i, if_valid, if_pc, imem_addr);
            end
        end
        id_ready = 1'b1;
        push(32'hBFC0000C, 1'b0);
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, e.pc, e.instr}) begin
            n_errors++; $display("FAIL bp_release: got v=%b pc=%h expected pc=%h", if_valid, if_pc, e.pc);
        end
    endtask

    task automatic test_redirect(input logic [31:0] target, input logic stall);
        logic [31:0] aligned;
        aligned = {target[31:2], 2'b00};
        id_ready = !stall; redirect_valid = 1'b1; redirect_target = target;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({if_valid, imem_addr} !== {1'b0, aligned}) begin
            n_errors++; $display("FAIL redir_flush %h: got v=%b addr=%h expected v=0 addr=%h", target, if_valid, imem_addr, aligned);
        end
        push(aligned, target[1:0] != 2'b00);
        push(aligned + 32'd4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            id_ready = 1'b1;
            e = sb.pop_front();
            n_checks++;
            if ({if_valid, if_pc, if_instr, if_pc_plus4, if_fault} !== {1'b1, e.pc, e.instr, e.pc + 32'd4, e.fault}) begin
                n_errors++; $display("FAIL redir_entry %h/%0d: got v=%b pc=%h p4=%h f=%b expected pc=%h f=%b",
                                     target, i, if_valid, if_pc, if_pc_plus4, if_fault, e.pc, e.fault);
            end
        end
    endtask

    task automatic test_halt_resume();
        logic [31:0] pc_hold;
        pc_hold = imem_addr;
        id_ready = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_checks++;
        if ({halted, if_valid, imem_addr} !== {1'b1, 1'b1, pc_hold}) begin
            n_errors++; $display("FAIL halt_enter: got h=%b v=%b addr=%h expected h=1 v=1 addr=%h", halted, if_valid, imem_addr, pc_hold);
        end
        tick();
        id_ready = 1'b1;
        tick();
        n_checks++;
        if ({halted, if_valid, imem_addr} !== {1'b1, 1'b0, pc_hold}) begin
            n_errors++; $display("FAIL halt_drain: got h=%b v=%b addr=%h expected h=1 v=0 addr=%h", halted, if_valid, imem_addr, pc_hold);
        end
        tick();
        n_checks++;
        if ({halted, if_valid, imem_addr} !== {1'b1, 1'b0, pc_hold}) begin
            n_errors++; $display("FAIL halt_stay: got h=%b v=%b addr=%h expected h=1 v=0 addr=%h", halted, if_valid, imem_addr, pc_hold);
        end
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        tick();
        halt_req = 1'b0; redirect_valid = 1'b0;
        n_checks++;
        if ({halted, if_valid, imem_addr} !== {1'b0, 1'b0, 32'hBFC00100}) begin
            n_errors++; $display("FAIL halt_resume: got h=%b v=%b addr=%h expected h=0 v=0 addr=bfc00100", halted, if_valid, imem_addr);
        end
        push(32'hBFC00100, 1'b0);
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, e.pc, e.instr}) begin
            n_errors++; $display("FAIL halt_refetch: got v=%b pc=%h expected pc=%h", if_valid, if_pc, e.pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        push(32'hFFFFFFFC, 1'b0);
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({if_valid, if_pc, if_instr, if_pc_plus4, imem_addr} !== {1'b1, e.pc, e.instr, 32'h0, 32'h0}) begin
            n_errors++; $display("FAIL wrap: got v=%b pc=%h p4=%h addr=%h expected pc=fffffffc p4=0 addr=0",
                                 if_valid, if_pc, if_pc_plus4, imem_addr);
        end
        push(32'h0, 1'b0);
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b1, e.pc, e.instr, 32'h4}) begin
            n_errors++; $display("FAIL wrap_next: got v=%b pc=%h p4=%h expected pc=0 p4=4", if_valid, if_pc, if_pc_plus4);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({if_valid, imem_addr, if_pc} !== {1'b0, 32'hBFC00000, 32'h0}) begin
            n_errors++; $display("FAIL async_reset: got v=%b addr=%h pc=%h expected v=0 addr=bfc00000 pc=0", if_valid, imem_addr, if_pc);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_boot: if_valid got %b expected 0", if_valid);
        end
        push(32'hBFC00000, 1'b0);
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, e.pc, e.instr}) begin
            n_errors++; $display("FAIL post_reset_fetch: got v=%b pc=%h instr=%h expected pc=%h", if_valid, if_pc, if_instr, e.pc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect(32'hBFC00040, 1'b1);
        test_redirect(32'hBFC00042, 1'b0);
        test_halt_resume();
        test_wrap_and_reset();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
